// File: rtl/dsp_pkg.sv
// Shared types and width helpers for the receiver DSP chain.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dsp_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_t;

    // A sum of 2^window_log2 squares of signed input_dw-bit samples never exceeds this width.
    function automatic int acc_width(input int input_dw, input int window_log2);
        return 2 * input_dw - 1 + window_log2;
    endfunction

endpackage

// File: rtl/signed_squarer.sv
// Registered signed x signed square with unsigned 2*DW-1 result and tag/valid pass-through.
// Latency: 1 cycle.
// Backpressure: none; clr synchronously empties the stage.
module signed_squarer #(
    parameter int DW    = 20,
    parameter int TAG_W = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_vld,
    input  logic signed [DW-1:0] in_dat,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_vld,
    output logic [2*DW-2:0]      out_dat,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int SQ_W = 2 * DW - 1;

    logic signed [2*DW-1:0] prod;
    logic [SQ_W-1:0]        sq;
    logic                   prod_unused_msb;

    // A square is non-negative and at most 2^(2*DW-2), so the top product bit is always zero.
    assign prod = in_dat * in_dat;
    assign {prod_unused_msb, sq} = prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            out_dat <= '0;
            out_tag <= '0;
        end else if (clr) begin
            out_vld <= 1'b0;
            out_dat <= '0;
            out_tag <= '0;
        end else begin
            out_vld <= in_vld;
            if (in_vld) begin
                out_dat <= sq;
                out_tag <= in_tag;
            end
        end
    end

endmodule

// File: rtl/power_window_accum.sv
// Windowed mean-power estimator: sums 2^WINDOW_LOG2 squares, publishes a saturated mean.
// Latency: valid_o 2 cycles after the cycle carrying the last sample of a window.
// Backpressure: none; every valid sample is consumed, en_i low discards the partial window.
module power_window_accum
    import dsp_pkg::*;
#(
    parameter int INPUT_DW     = 20,
    parameter int WINDOW_LOG2  = 8,
    parameter int OUTPUT_DW    = 32,
    parameter int OUTPUT_SHIFT = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [INPUT_DW-1:0] data_i,
    input  logic                       valid_i,
    input  logic                       en_i,
    output logic [OUTPUT_DW-1:0]       power_o,
    output logic                       valid_o,
    output logic                       sat_o
);

    localparam int SQ_W  = 2 * INPUT_DW - 1;
    localparam int ACC_W = acc_width(INPUT_DW, WINDOW_LOG2);
    // Mean is kept wide enough to detect values above the output range.
    localparam int MEAN_W = (ACC_W > OUTPUT_DW) ? ACC_W : OUTPUT_DW + 1;
    localparam int SHIFT  = WINDOW_LOG2 + OUTPUT_SHIFT;
    localparam logic [MEAN_W-1:0] OUT_MAX = MEAN_W'({OUTPUT_DW{1'b1}});

    acc_state_t state, state_nxt;

    logic                   run;
    logic                   clr;
    logic                   accept;
    logic                   last;
    logic [WINDOW_LOG2-1:0] cnt;
    logic                   sq_vld;
    logic                   sq_last;
    logic [SQ_W-1:0]        sq_dat;
    logic [ACC_W-1:0]       acc;
    logic [ACC_W-1:0]       sum;
    logic [MEAN_W-1:0]      mean;
    logic                   mean_sat;
    logic [OUTPUT_DW-1:0]   power_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Samples only count in ACCUM with en_i still high, so the entry cycle never counts.
    always_comb begin
        state_nxt = state;
        run       = 1'b0;
        case (state)
            IDLE: begin
                if (en_i) begin
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                run = en_i;
                if (!en_i) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign clr    = !run;
    assign accept = run && valid_i;
    assign last   = accept && (&cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= cnt + 1'b1;
        end
    end

    signed_squarer #(
        .DW    (INPUT_DW),
        .TAG_W (1)
    ) u_squarer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .in_vld  (accept),
        .in_dat  (data_i),
        .in_tag  (last),
        .out_vld (sq_vld),
        .out_dat (sq_dat),
        .out_tag (sq_last)
    );

    assign sum       = acc + ACC_W'(sq_dat);
    assign mean      = MEAN_W'(sum) >> SHIFT;
    assign mean_sat  = mean > OUT_MAX;
    assign power_nxt = mean_sat ? {OUTPUT_DW{1'b1}} : mean[OUTPUT_DW-1:0];

    // The last square restarts the accumulator so the next window can follow immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (sq_vld) begin
            acc <= sq_last ? '0 : sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            power_o <= '0;
            sat_o   <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (!clr && sq_vld && sq_last) begin
                power_o <= power_nxt;
                sat_o   <= mean_sat;
                valid_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_power_window_accum.sv
// Bench for power_window_accum: three configurations share one stimulus stream.
// Expected outputs come from a window-level model of the estimator.
module tb_power_window_accum;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en_i = 1'b0;
    logic              valid_i = 1'b0;
    logic signed [7:0] data_i = '0;

    logic [15:0] pwr_a;
    logic [11:0] pwr_b;
    logic [15:0] pwr_c;
    logic        vld_a, vld_b, vld_c;
    logic        sat_a, sat_b, sat_c;

    always #5 clk = ~clk;

    power_window_accum #(.INPUT_DW(8), .WINDOW_LOG2(2), .OUTPUT_DW(16), .OUTPUT_SHIFT(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i), .en_i(en_i),
        .power_o(pwr_a), .valid_o(vld_a), .sat_o(sat_a));

    power_window_accum #(.INPUT_DW(8), .WINDOW_LOG2(2), .OUTPUT_DW(12), .OUTPUT_SHIFT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i), .en_i(en_i),
        .power_o(pwr_b), .valid_o(vld_b), .sat_o(sat_b));

    power_window_accum #(.INPUT_DW(8), .WINDOW_LOG2(2), .OUTPUT_DW(16), .OUTPUT_SHIFT(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i), .en_i(en_i),
        .power_o(pwr_c), .valid_o(vld_c), .sat_o(sat_c));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Window-level model: per-config output width and extra shift.
    int     cfg_odw[3]   = '{16, 12, 16};
    int     cfg_shift[3] = '{0, 0, 2};
    int     win_q[$];
    bit     prev_en = 1'b0;
    bit     pend = 1'b0;
    longint pend_sum = 0;
    longint exp_pwr[3] = '{0, 0, 0};
    bit     exp_vld[3] = '{0, 0, 0};
    bit     exp_sat[3] = '{0, 0, 0};
    int     exp_cnt[3] = '{0, 0, 0};
    int     got_cnt[3] = '{0, 0, 0};

    task automatic publish(input longint sum);
        for (int k = 0; k < 3; k++) begin
            longint mean;
            longint lim;
            mean = sum / (64'sd1 << (2 + cfg_shift[k]));
            lim  = (64'sd1 << cfg_odw[k]) - 1;
            exp_vld[k] = 1'b1;
            exp_sat[k] = mean > lim;
            exp_pwr[k] = (mean > lim) ? lim : mean;
            exp_cnt[k]++;
        end
    endtask

    task automatic check_outputs();
        chk("a_vld", vld_a, exp_vld[0]);
        chk("a_pwr", pwr_a, exp_pwr[0]);
        chk("a_sat", sat_a, exp_sat[0]);
        chk("b_vld", vld_b, exp_vld[1]);
        chk("b_pwr", pwr_b, exp_pwr[1]);
        chk("b_sat", sat_b, exp_sat[1]);
        chk("c_vld", vld_c, exp_vld[2]);
        chk("c_pwr", pwr_c, exp_pwr[2]);
        chk("c_sat", sat_c, exp_sat[2]);
        got_cnt[0] += int'(vld_a);
        got_cnt[1] += int'(vld_b);
        got_cnt[2] += int'(vld_c);
    endtask

    // One clock cycle: check what the last edge produced, then drive and model the next cycle.
    task automatic step(input bit r, input bit e, input bit v, input int d);
        logic [7:0] d8;
        @(negedge clk);
        check_outputs();
        d8      = d[7:0];
        rst_n   = r;
        en_i    = e;
        valid_i = v;
        data_i  = d8;
        for (int k = 0; k < 3; k++) exp_vld[k] = 1'b0;
        if (!r) begin
            win_q.delete();
            pend    = 1'b0;
            prev_en = 1'b0;
            for (int k = 0; k < 3; k++) begin
                exp_pwr[k] = 0;
                exp_sat[k] = 1'b0;
            end
            #1;
            chk("rst_now_pwr", longint'(pwr_a) + longint'(pwr_b) + longint'(pwr_c), 0);
            chk("rst_now_flags", {vld_a, vld_b, vld_c, sat_a, sat_b, sat_c}, 0);
        end else begin
            // The square of the last sample is only committed if enable survives its second cycle.
            if (pend && e) publish(pend_sum);
            pend = 1'b0;
            if (!(prev_en && e)) begin
                win_q.delete();
            end else if (v) begin
                win_q.push_back(d);
                if (win_q.size() == 4) begin
                    pend_sum = 0;
                    foreach (win_q[i]) pend_sum += longint'(win_q[i]) * longint'(win_q[i]);
                    pend = 1'b1;
                    win_q.delete();
                end
            end
            prev_en = e;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 1, 0, 0);
    endtask

    initial begin
        int seq_a[8];
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);

        // Entry cycle carries a sample that must be ignored.
        step(1, 1, 1, 100);
        step(1, 1, 1, 3);
        step(1, 1, 1, -3);
        step(1, 1, 1, 3);
        step(1, 1, 1, -3);
        idle(3);
        chk("basic_pwr", pwr_a, 9);
        chk("basic_sat", sat_a, 0);

        for (int i = 0; i < 4; i++) step(1, 1, 1, -128);
        idle(3);
        chk("worst_b_pwr", pwr_b, 4095);
        chk("worst_b_sat", sat_b, 1);
        chk("worst_a_pwr", pwr_a, 16384);
        chk("worst_a_sat", sat_a, 0);

        seq_a = '{1, 2, 3, 4, 5, 6, 7, 8};
        for (int i = 0; i < 8; i++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) step(1, 1, 0, 77);
            step(1, 1, 1, seq_a[i]);
        end
        idle(3);
        chk("b2b_pwr", pwr_a, 43);

        for (int i = 0; i < 3; i++) step(1, 1, 1, 5);
        step(1, 0, 1, 5);
        step(1, 0, 0, 0);
        chk("abort_hold", pwr_a, 43);
        step(1, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 2);
        idle(3);
        chk("abort_pwr", pwr_a, 4);

        for (int i = 0; i < 4; i++) step(1, 1, 1, 8);
        idle(3);
        chk("shift_pwr", pwr_c, 16);

        step(1, 1, 1, 50);
        step(1, 1, 1, 50);
        step(0, 1, 1, 50);
        step(1, 1, 1, 50);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 1);
        idle(3);
        chk("post_rst_pwr", pwr_a, 1);

        // Back-to-back with the last square's enable dropping in stage 2.
        for (int i = 0; i < 4; i++) step(1, 1, 1, 9);
        step(1, 0, 0, 0);
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            bit r, e, v;
            int d;
            r = $urandom_range(0, 299) != 0;
            e = $urandom_range(0, 24) != 0;
            v = $urandom_range(0, 9) < 7;
            d = int'($urandom_range(0, 255)) - 128;
            step(r, e, v, d);
        end

        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        chk("pulses_a", got_cnt[0], exp_cnt[0]);
        chk("pulses_b", got_cnt[1], exp_cnt[1]);
        chk("pulses_c", got_cnt[2], exp_cnt[2]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
